// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: register scoreboard for EXE/MEM/WB plus stall/flush/bubble control.
// Latency: controls are combinational from registered state and current inputs (0 cycles).
// Backpressure: a RAW hazard holds IF/ID and injects a bubble into EXE until the writer clears.
module hazard_ctrl #(
   parameter int FORWARD_EN   = 0,
   parameter int BRANCH_FLUSH = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      id_instruction,
   input  logic             id_valid,
   input  logic             branch,
   input  logic             jump,
   output logic             stall_if,
   output logic             stall_id,
   output logic             flush_if,
   output logic             flush_id,
   output logic             bubble_exe,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic [1:0] {S_RUN, S_STALL, S_FLUSH} state_t;

   // Cycles of flush_id still owed after the branch cycle itself.
   localparam logic [2:0] FLUSH_LOAD = 3'(BRANCH_FLUSH - 1);

   state_t           state_q;
   logic [2:0]       fcnt_q;
   logic             exe_vld_q, mem_vld_q, wb_vld_q;
   logic [4:0]       exe_dst_q, mem_dst_q, wb_dst_q;
   logic             exe_ld_q;
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   logic [5:0] op;
   logic [4:0] rs, rt, rd;
   logic       use_rs, use_rt, has_dst, is_load;
   logic [4:0] dst;
   logic       hazard, flush_active, issue, flush_ev;
   logic       unused_bits;

   assign op = id_instruction[31:26];
   assign rs = id_instruction[25:21];
   assign rt = id_instruction[20:16];
   assign rd = id_instruction[15:11];
   assign unused_bits = ^id_instruction[10:0];

   // Decode source/destination usage of the instruction sitting in ID.
   always_comb begin
      use_rs  = 1'b0;
      use_rt  = 1'b0;
      has_dst = 1'b0;
      dst     = 5'd0;
      is_load = 1'b0;
      case (op)
         6'h00: begin use_rs = 1'b1; use_rt = 1'b1; has_dst = 1'b1; dst = rd; end
         6'h23: begin use_rs = 1'b1; has_dst = 1'b1; dst = rt; is_load = 1'b1; end
         6'h08: begin use_rs = 1'b1; has_dst = 1'b1; dst = rt; end
         6'h2B, 6'h04: begin use_rs = 1'b1; use_rt = 1'b1; end
         default: ;
      endcase
   end

   // True when a pending writer's destination matches a nonzero source of ID.
   function automatic logic src_hit(input logic [4:0] wdst, input logic urs, input logic urt,
                                    input logic [4:0] srs, input logic [4:0] srt);
      return (urs && (srs != 5'd0) && (srs == wdst)) ||
             (urt && (srt != 5'd0) && (srt == wdst));
   endfunction

   // Hazard detection: without forwarding any in-flight writer blocks; with it only a load in EXE.
   always_comb begin
      hazard = 1'b0;
      if (FORWARD_EN == 0) begin
         hazard = id_valid &&
                  ((exe_vld_q && src_hit(exe_dst_q, use_rs, use_rt, rs, rt)) ||
                   (mem_vld_q && src_hit(mem_dst_q, use_rs, use_rt, rs, rt)) ||
                   (wb_vld_q  && src_hit(wb_dst_q,  use_rs, use_rt, rs, rt)));
      end else begin
         hazard = id_valid && exe_vld_q && exe_ld_q &&
                  src_hit(exe_dst_q, use_rs, use_rt, rs, rt);
      end
   end

   assign flush_active = (state_q == S_FLUSH) && (fcnt_q != 3'd0);

   // Control outputs in priority order: branch, flush tail, hazard, jump; all zero in reset.
   always_comb begin
      stall_if = 1'b0;
      stall_id = 1'b0;
      flush_if = 1'b0;
      flush_id = 1'b0;
      if (rst) begin
         flush_id = 1'b0;
      end else if (branch) begin
         flush_if = 1'b1;
         flush_id = 1'b1;
      end else if (flush_active) begin
         flush_id = 1'b1;
      end else if (hazard) begin
         stall_if = 1'b1;
         stall_id = 1'b1;
         flush_id = 1'b1;
      end else if (jump && id_valid) begin
         flush_if = 1'b1;
      end
   end

   assign bubble_exe = flush_id;
   assign issue      = id_valid && !stall_id && !flush_id;
   assign flush_ev   = branch || (jump && flush_if);

   // Sequencer state and remaining flush cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_RUN;
         fcnt_q  <= 3'd0;
      end else if (branch) begin
         state_q <= (FLUSH_LOAD != 3'd0) ? S_FLUSH : S_RUN;
         fcnt_q  <= FLUSH_LOAD;
      end else if (flush_active) begin
         fcnt_q  <= fcnt_q - 3'd1;
         state_q <= (fcnt_q == 3'd1) ? S_RUN : S_FLUSH;
      end else if (hazard) begin
         state_q <= S_STALL;
      end else begin
         state_q <= S_RUN;
      end
   end

   // Destination scoreboard shifts every cycle; EXE slot loads only on a real issue with a dest.
   always_ff @(posedge clk) begin
      if (rst) begin
         exe_vld_q <= 1'b0;
         mem_vld_q <= 1'b0;
         wb_vld_q  <= 1'b0;
         exe_dst_q <= 5'd0;
         mem_dst_q <= 5'd0;
         wb_dst_q  <= 5'd0;
         exe_ld_q  <= 1'b0;
      end else begin
         wb_vld_q  <= mem_vld_q;
         wb_dst_q  <= mem_dst_q;
         mem_vld_q <= exe_vld_q;
         mem_dst_q <= exe_dst_q;
         exe_vld_q <= issue && has_dst && (dst != 5'd0);
         exe_dst_q <= dst;
         exe_ld_q  <= issue && is_load;
      end
   end

   // Saturating event counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_id && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (flush_ev && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;

endmodule
